// File: rtl/mips_bus_pkg.sv
// Shared constants for the MIPS_System data-RAM arbiter.
// Port ids, lock FSM encodings and default bus widths.
package mips_bus_pkg;

  localparam int AW_DEF        = 11;
  localparam int DW_DEF        = 32;
  localparam int MAX_BURST_DEF = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick; on a tie the port that
// did not win last time is chosen.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port data RAM arbiter: CPU port 0, loader port 1.
// Round-robin with bounded burst lock and a 1-cycle read return.
module mips_mem_arbiter
  import mips_bus_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            m0_req,
  input  logic            m0_lock,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,

  input  logic            m1_req,
  input  logic            m1_lock,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,

  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);

  arb_state_e    r_state;
  logic          r_last;
  logic [CW-1:0] r_bcnt;
  logic          r_rpend;
  logic          r_rsel;

  logic [1:0]    w_req;
  logic [1:0]    w_rr_gnt;
  logic [1:0]    w_gnt;
  logic          w_acc;
  logic          w_gp;
  logic          w_cont;
  logic          w_rd_acc;
  logic          w_sel_we;
  logic          w_sel_lock;
  logic [BW-1:0] w_sel_be;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  assign w_req = {m1_req, m0_req};

  arb_rr2 u_rr (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_rr_gnt)
  );

  // Owner keeps the RAM until its burst budget runs out
  // while the other port is waiting.
  always_comb begin
    w_gnt = 2'b00;
    case (r_state)
      LOCK0: begin
        if (!m0_req)
          w_gnt = w_rr_gnt;
        else if (m1_req && r_bcnt == BMAX)
          w_gnt = 2'b10;
        else
          w_gnt = 2'b01;
      end
      LOCK1: begin
        if (!m1_req)
          w_gnt = w_rr_gnt;
        else if (m0_req && r_bcnt == BMAX)
          w_gnt = 2'b01;
        else
          w_gnt = 2'b10;
      end
      default: w_gnt = w_rr_gnt;
    endcase
    if (reset)
      w_gnt = 2'b00;
  end

  assign w_acc  = |w_gnt;
  assign w_gp   = w_gnt[1];
  assign w_cont = (r_state == LOCK0 && w_gnt[0]) ||
                  (r_state == LOCK1 && w_gnt[1]);

  assign w_sel_we    = w_gp ? m1_we    : m0_we;
  assign w_sel_lock  = w_gp ? m1_lock  : m0_lock;
  assign w_sel_be    = w_gp ? m1_be    : m0_be;
  assign w_sel_addr  = w_gp ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_gp ? m1_wdata : m0_wdata;

  assign w_rd_acc = w_acc && !w_sel_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB;
      r_last  <= PORT1;
      r_bcnt  <= '0;
      r_rpend <= 1'b0;
      r_rsel  <= PORT0;
    end else begin
      r_rpend <= w_rd_acc;
      if (w_rd_acc)
        r_rsel <= w_gp;
      if (w_acc) begin
        r_last <= w_gp;
        if (w_cont) begin
          if (r_bcnt != BMAX)
            r_bcnt <= r_bcnt + CW'(1);
          if (!w_sel_lock) begin
            r_state <= ARB;
            r_bcnt  <= '0;
          end
        end else if (w_sel_lock) begin
          r_state <= w_gp ? LOCK1 : LOCK0;
          r_bcnt  <= CW'(1);
        end else begin
          r_state <= ARB;
          r_bcnt  <= '0;
        end
      end else begin
        r_state <= ARB;
        r_bcnt  <= '0;
      end
    end
  end

  assign m0_gnt = w_gnt[0];
  assign m1_gnt = w_gnt[1];

  assign mem_en    = w_acc;
  assign mem_we    = (w_acc && w_sel_we) ? w_sel_be : '0;
  assign mem_addr  = w_acc ? w_sel_addr  : '0;
  assign mem_wdata = w_acc ? w_sel_wdata : '0;

  assign m0_rvalid = r_rpend && (r_rsel == PORT0) && !reset;
  assign m1_rvalid = r_rpend && (r_rsel == PORT1) && !reset;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: RAM model, per-cycle
// reference model and directed scenarios.
module tb_mips_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req, m0_lock, m0_we;
  logic [BW-1:0] m0_be;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_lock, m1_we;
  logic [BW-1:0] m1_be;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_lock   (m0_lock),
    .m0_we     (m0_we),
    .m0_be     (m0_be),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_we     (m1_we),
    .m1_be     (m1_be),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Environment RAM and the model's private copy of it
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] sh  [2**AW];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == '0)
        mem_rdata <= ram[mem_addr];
      else
        for (int b = 0; b < BW; b++)
          if (mem_we[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // Reference model: who owns the bus, how long, who won last
  int            own = -1;
  int            burst = 0;
  int            lastp = 1;
  int            pend = -1;
  logic [DW-1:0] pend_data = '0;

  always @(negedge clk) begin : model
    int            g;
    logic          rq [2];
    logic          lk [2];
    logic          wv [2];
    logic [BW-1:0] bv [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    rq[0] = m0_req;  rq[1] = m1_req;
    lk[0] = m0_lock; lk[1] = m1_lock;
    wv[0] = m0_we;   wv[1] = m1_we;
    bv[0] = m0_be;   bv[1] = m1_be;
    ad[0] = m0_addr; ad[1] = m1_addr;
    wd[0] = m0_wdata; wd[1] = m1_wdata;
    if (reset) begin
      chk("m_rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
      chk("m_rst_en", mem_en, 1'b0);
      chk("m_rst_we", mem_we, '0);
      chk("m_rst_rv", {m1_rvalid, m0_rvalid}, 2'b00);
      own = -1; burst = 0; lastp = 1; pend = -1;
    end else begin
      chk("m_rv0", m0_rvalid, pend == 0);
      chk("m_rv1", m1_rvalid, pend == 1);
      chk("m_rd0", m0_rdata, (pend == 0) ? pend_data : '0);
      chk("m_rd1", m1_rdata, (pend == 1) ? pend_data : '0);
      g = -1;
      if (own >= 0 && rq[own])
        g = (rq[1-own] && burst == MB) ? 1 - own : own;
      else if (rq[0] && rq[1])
        g = 1 - lastp;
      else if (rq[0])
        g = 0;
      else if (rq[1])
        g = 1;
      chk("m_gnt", {m1_gnt, m0_gnt},
          (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00);
      chk("m_en", mem_en, g >= 0);
      chk("m_we", mem_we, (g >= 0 && wv[g]) ? bv[g] : '0);
      chk("m_addr", mem_addr, (g >= 0) ? ad[g] : '0);
      chk("m_wdata", mem_wdata, (g >= 0) ? wd[g] : '0);
      pend = -1;
      if (g < 0) begin
        own = -1;
      end else begin
        if (g == own) begin
          burst = (burst < MB) ? burst + 1 : MB;
          if (!lk[g]) own = -1;
        end else if (lk[g]) begin
          own = g; burst = 1;
        end else begin
          own = -1;
        end
        lastp = g;
        if (wv[g]) begin
          for (int b = 0; b < BW; b++)
            if (bv[g][b]) sh[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
        end else begin
          pend = g;
          pend_data = sh[ad[g]];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int seq[$];
  int n0, both, gs;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = 32'hA5A50000 ^ (i * 32'h00010003);
      sh[i]  = ram[i];
    end
    ram[11'h010] = 32'hDEADBEEF; sh[11'h010] = 32'hDEADBEEF;
    ram[11'h020] = 32'hFFFFFFFF; sh[11'h020] = 32'hFFFFFFFF;
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_be = '0;
    m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_be = '0;
    m1_addr = '0; m1_wdata = '0;

    step(); step();
    m0_req = 1;
    @(negedge clk);
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    step();
    reset = 0; m0_req = 0;

    // single read from port 0
    m0_addr = 11'h010; m0_req = 1;
    @(negedge clk);
    chk("t1_gnt", m0_gnt, 1'b1);
    step();
    m0_req = 0;
    @(negedge clk);
    chk("t1_rvalid", m0_rvalid, 1'b1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rvalid", m1_rvalid, 1'b0);
    step();

    // plain alternation straight out of reset
    do_reset();
    m0_addr = 11'h001; m1_addr = 11'h002;
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_gnt", {m1_gnt, m0_gnt}, (i % 2) ? 2'b10 : 2'b01);
      chk("t2_addr", mem_addr, (i % 2) ? 11'h002 : 11'h001);
      step();
    end
    m0_req = 0; m1_req = 0;
    step();

    // partial write from port 1 then read back on port 0
    m1_we = 1; m1_be = 4'b0011; m1_wdata = 32'h12345678;
    m1_addr = 11'h020; m1_req = 1;
    @(negedge clk);
    chk("t3_wgnt", m1_gnt, 1'b1);
    step();
    m1_req = 0; m1_we = 0; m1_be = '0;
    m0_addr = 11'h020; m0_req = 1;
    @(negedge clk);
    chk("t3_rgnt", m0_gnt, 1'b1);
    step();
    m0_req = 0;
    @(negedge clk);
    chk("t3_rdata", m0_rdata, 32'hFFFF5678);
    chk("t3_m1_rvalid", m1_rvalid, 1'b0);
    step();

    // locked burst on port 0 against a continuous port 1
    do_reset();
    m0_addr = 11'h100; m0_lock = 1; m0_req = 1;
    m1_addr = 11'h200; m1_lock = 0; m1_req = 1;
    n0 = 0; both = 0;
    for (int c = 0; c < 40 && n0 < 12; c++) begin
      @(negedge clk);
      if (m0_gnt && m1_gnt) both++;
      gs = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
      seq.push_back(gs);
      step();
      if (gs == 0) begin
        n0++;
        m0_addr = m0_addr + 11'd1;
        if (n0 == 12) begin
          m0_req = 0; m0_lock = 0;
        end
      end
    end
    m1_req = 0;
    chk("t4_m0_count", n0, 12);
    chk("t4_both", both, 0);
    chk("t4_len", seq.size() >= 10, 1'b1);
    if (seq.size() >= 10) begin
      for (int i = 0; i < 8; i++) chk("t4_burst", seq[i], 0);
      chk("t4_m1_turn", seq[8], 1);
      chk("t4_m0_resume", seq[9], 0);
    end
    step();

    // reset swallows a pending read
    do_reset();
    m0_addr = 11'h010; m0_req = 1;
    @(negedge clk);
    chk("t5_gnt", m0_gnt, 1'b1);
    step();
    m0_req = 0; reset = 1;
    @(negedge clk);
    chk("t5_rvalid", m0_rvalid, 1'b0);
    step();
    reset = 0; m0_req = 1; m1_req = 1;
    @(negedge clk);
    chk("t5_tie", {m1_gnt, m0_gnt}, 2'b01);
    step();
    m0_req = 0; m1_req = 0;
    step();

    // lock owner walks away, port 1 takes over at once
    m0_addr = 11'h030; m0_lock = 1; m0_req = 1;
    @(negedge clk);
    chk("t6_lock_gnt", m0_gnt, 1'b1);
    step();
    m0_req = 0; m0_lock = 0;
    m1_addr = 11'h031; m1_req = 1;
    @(negedge clk);
    chk("t6_m1_same", m1_gnt, 1'b1);
    chk("t6_m0_off", m0_gnt, 1'b0);
    step();
    m0_req = 1;
    @(negedge clk);
    chk("t6_arb_tie", {m1_gnt, m0_gnt}, 2'b01);
    step();
    m0_req = 0; m1_req = 0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
